data_mem_wait: RTL

Word-addressed data memory with a fixed, parameterized access latency. It sits directly downstream of the single-cycle MIPS datapath's data port, consuming `data_adr` and `data_out` and producing `data_in`. While an access is in progress it raises `stall`; the controller uses `stall` to hold the PC and suppress `reg_write`, so the current instruction stays frozen until the access completes.

---
 rtl/data_mem_wait.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_mem_wait.sv
// data_mem_wait: word-addressed data memory with a fixed access latency.
// Accepts one aligned load/store in IDLE, stays busy for LATENCY cycles,
// then spends one DONE cycle with stall low so the CPU can commit.
module data_mem_wait #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_write;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_read_data;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_aligned;
    logic            w_accept;
    logic            w_fire;
    logic            w_unused_adr;

    assign w_req     = mem_read | mem_write;
    assign w_aligned = (adr[1:0] == 2'b00);
    assign w_accept  = (r_state == S_IDLE) && w_req && w_aligned;
    assign w_fire    = (r_state == S_BUSY) && (r_cnt == '0);
    assign read_data = r_read_data;

    // Upper address bits wrap away; they are intentionally not decoded.
    assign w_unused_adr = ^adr[31:AW+2];

    // State register; reset returns to IDLE at once, abandoning any access.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and handshake outputs; both outputs are held low in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        stall        = 1'b0;
        misaligned   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req && !w_aligned) begin
                    misaligned = 1'b1;
                end else if (w_req) begin
                    stall        = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (r_cnt == '0) w_next_state = S_DONE;
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (rst) begin
            stall      = 1'b0;
            misaligned = 1'b0;
        end
    end

    // Latch the request on acceptance and count down the busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_cnt      <= CW'(LATENCY - 1);
            r_is_write <= mem_write;  // read+write together acts as a write
            r_idx      <= adr[AW+1:2];
            r_wdata    <= write_data;
        end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Storage array; written only on the final busy cycle of a store.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto plain RAM; contents
        // are undefined until written.
        if (w_fire && r_is_write) r_mem[r_idx] <= r_wdata;
    end

    // Load result register; holds until the next load completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_read_data <= '0;
        else if (w_fire && !r_is_write) r_read_data <= r_mem[r_idx];
    end

endmodule
